// File: rtl/avalon_pkg.sv
// ============================================================================
// Module   : avalon_pkg
// Purpose  : Shared enums and width helpers for the Avalon-MM slave memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package avalon_pkg;

  typedef enum logic [2:0] {
    WAITREQ  = 3'd0,
    FIXED    = 3'd1,
    PIPE_VAR = 3'd2,
    PIPE_FIX = 3'd3,
    BURST    = 3'd4
  } avalon_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } m0_state_e;

  function automatic int data_width(input int nbytes);
    return 8 * nbytes;
  endfunction

  function automatic int be_width(input int nbytes);
    return nbytes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avalon_slave_mem_if.sv
// ============================================================================
// Module   : avalon_slave_mem_if
// Purpose  : Avalon-MM bus bundle with master and slave views.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface avalon_slave_mem_if
  import avalon_pkg::*;
#(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8
);
  logic [NBADDRBITS-1:0]                  address;
  logic [be_width(NBDATABYTES)-1:0]       byteenable;
  logic [data_width(NBDATABYTES)-1:0]     writedata;
  logic                                   read;
  logic                                   write;
  logic                                   waitrequest;
  logic [data_width(NBDATABYTES)-1:0]     readdata;
  logic                                   readdatavalid;

  modport master (
    output address, byteenable, writedata, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write,
    output waitrequest, readdata, readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/avalon_rsp_pipe.sv
// ============================================================================
// Module   : avalon_rsp_pipe
// Purpose  : Fixed-depth {valid, data} shift register for read responses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_rsp_pipe #(
  parameter int LATENCY = 3,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic [LATENCY-1:0] vld;
  logic [DW-1:0]      dat [LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
    end else begin
      vld[0] <= push;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Payload needs no reset: it is only observed alongside its valid bit.
  always_ff @(posedge clk) begin
    dat[0] <= push_data;
    for (int i = 1; i < LATENCY; i++) begin
      dat[i] <= dat[i-1];
    end
  end

  assign valid = vld[LATENCY-1];
  assign data  = dat[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/avalon_slave_mem.sv
// ============================================================================
// Module   : avalon_slave_mem
// Purpose  : Avalon-MM slave memory model, waitrequest or pipelined timing.
//            Optional bus protocol checker enabled by AVS_PROTOCOL_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_slave_mem
  import avalon_pkg::*;
#(
  parameter int AVALONMODE  = 0,
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WAITCYCLES  = 2,
  parameter int LATENCY     = 3,
  parameter int MAXPENDING  = 2
) (
  input  logic               clk,
  input  logic               rst,
  avalon_slave_mem_if.slave  bus
`ifdef AVS_PROTOCOL_CHECK_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam int DW    = data_width(NBDATABYTES);
  localparam int DEPTH = 2 ** NBADDRBITS;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic          ready;
  logic          waitreq;
  logic          rdv;
  logic          hold_en;
  logic [DW-1:0] hold_d;
  logic [DW-1:0] rd_hold;

  // Stall for one cycle after reset release so no transfer straddles it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready <= 1'b0;
    else      ready <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < NBDATABYTES; b++) begin
        if (bus.byteenable[b]) begin
          mem[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
      end
    end
  end

  assign mem_rdata = mem[bus.address];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rd_hold <= '0;
    else if (hold_en) rd_hold <= hold_d;
  end

  assign bus.readdata      = hold_en ? hold_d : rd_hold;
  assign bus.waitrequest   = waitreq;
  assign bus.readdatavalid = rdv;

  if ((WAITCYCLES < 0) || (WAITCYCLES > 15) || (LATENCY < 1) || (LATENCY > 15) ||
      (MAXPENDING < 1) || (MAXPENDING > LATENCY)) begin : g_bad_cfg
    $fatal(1, "avalon_slave_mem: timing parameters out of range");
  end

  if (AVALONMODE == int'(WAITREQ)) begin : g_waitreq
    localparam logic [3:0] WC = 4'(WAITCYCLES);

    m0_state_e  state, state_n;
    logic [3:0] wcnt, wcnt_n;
    logic       req;
    logic       done;

    assign req  = bus.read | bus.write;
    assign done = ready && req && (wcnt == WC);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        wcnt  <= '0;
      end else begin
        state <= state_n;
        wcnt  <= wcnt_n;
      end
    end

    always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      if (ready) begin
        case (state)
          IDLE: begin
            if (req && !done) begin
              state_n = WAIT;
              wcnt_n  = 4'd1;
            end
          end
          WAIT: begin
            // A withdrawn request abandons the transfer without touching memory.
            if (!req || done) begin
              state_n = IDLE;
              wcnt_n  = '0;
            end else begin
              wcnt_n = wcnt + 4'd1;
            end
          end
          default: begin
            state_n = IDLE;
            wcnt_n  = '0;
          end
        endcase
      end
    end

    assign waitreq = !ready || (req && (wcnt != WC));
    assign mem_we  = done && bus.write;
    assign hold_en = done && bus.read && !bus.write;
    assign hold_d  = mem_rdata;
    assign rdv     = 1'b0;

  end else if (AVALONMODE == int'(PIPE_VAR)) begin : g_pipe
    localparam int            PW   = $clog2(MAXPENDING + 1);
    localparam logic [PW-1:0] PMAX = PW'(MAXPENDING);

    logic [PW-1:0] pending;
    logic          acc_rd;
    logic          acc_wr;
    logic          pvalid;
    logic [DW-1:0] pdata;

    assign waitreq = !ready || (pending == PMAX);
    assign acc_rd  = bus.read && !bus.write && !waitreq;
    assign acc_wr  = bus.write && !waitreq;

    avalon_rsp_pipe #(
      .LATENCY (LATENCY),
      .DW      (DW)
    ) u_rsp_pipe (
      .clk       (clk),
      .rst       (rst),
      .push      (acc_rd),
      .push_data (mem_rdata),
      .valid     (pvalid),
      .data      (pdata)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pending <= '0;
      end else if (acc_rd && !pvalid && (pending != PMAX)) begin
        pending <= pending + 1'b1;
      end else if (!acc_rd && pvalid && (pending != '0)) begin
        pending <= pending - 1'b1;
      end
    end

    assign mem_we  = acc_wr;
    assign hold_en = pvalid;
    assign hold_d  = pdata;
    assign rdv     = pvalid;

  end else begin : g_bad_mode
    $fatal(1, "avalon_slave_mem: unsupported AVALONMODE %0d", AVALONMODE);
  end

`ifdef AVS_PROTOCOL_CHECK_EN
  localparam bit IS_M0 = (AVALONMODE == int'(WAITREQ));

  logic                  prev_stall;
  logic                  prev_read;
  logic                  prev_write;
  logic [NBADDRBITS-1:0] prev_addr;
  logic [DW-1:0]         prev_wdata;
  logic                  proto_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_stall <= 1'b0;
      prev_read  <= 1'b0;
      prev_write <= 1'b0;
      prev_addr  <= '0;
      prev_wdata <= '0;
    end else begin
      prev_stall <= waitreq && (bus.read || bus.write);
      prev_read  <= bus.read;
      prev_write <= bus.write;
      prev_addr  <= bus.address;
      prev_wdata <= bus.writedata;
    end
  end

  assign proto_evt = (bus.read && bus.write) ||
                     (IS_M0 && prev_stall &&
                      ((bus.read != prev_read) || (bus.write != prev_write) ||
                       (bus.address != prev_addr) || (bus.writedata != prev_wdata)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (proto_evt) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      $error("avalon_slave_mem: bus protocol violation at %0t", $time);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_avalon_slave_mem.sv
// ============================================================================
// Module   : tb_avalon_slave_mem
// Purpose  : Directed scoreboard bench for both slave timing modes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_avalon_slave_mem;

  localparam int NB = 2;
  localparam int AB = 8;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  logic [DW-1:0] q0[$];
  exp_t          q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_slave_mem_if #(.NBDATABYTES(NB), .NBADDRBITS(AB)) bus0 ();
  avalon_slave_mem_if #(.NBDATABYTES(NB), .NBADDRBITS(AB)) bus2 ();

`ifdef AVS_PROTOCOL_CHECK_EN
  logic [15:0] err0;
  logic [15:0] err2;
`endif

  avalon_slave_mem #(
    .AVALONMODE(0), .NBDATABYTES(NB), .NBADDRBITS(AB),
    .WAITCYCLES(2), .LATENCY(3), .MAXPENDING(2)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
`ifdef AVS_PROTOCOL_CHECK_EN
    , .err_count(err0)
`endif
  );

  avalon_slave_mem #(
    .AVALONMODE(2), .NBDATABYTES(NB), .NBADDRBITS(AB),
    .WAITCYCLES(2), .LATENCY(3), .MAXPENDING(2)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
`ifdef AVS_PROTOCOL_CHECK_EN
    , .err_count(err2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Mode 0 read completions are scored here.
  always @(negedge clk) begin
    if (rst && bus0.read && !bus0.write && !bus0.waitrequest) begin
      check("m0_sb_nonempty", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) check("m0_rdata", 32'(bus0.readdata), 32'(q0.pop_front()));
    end
  end

  // Mode 2 returns: data order and exact latency from acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (bus2.readdatavalid) begin
      check("m2_rdv_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("m2_rdata", 32'(bus2.readdata), 32'(e.data));
        check("m2_latency", 32'(cyc - e.acc), 32'd3);
      end
    end
  end

  task automatic m0_xfer(input logic rd, input logic wr, input logic [AB-1:0] a,
                         input logic [DW-1:0] wd, input logic [NB-1:0] be, output int stalls);
    bus0.address = a; bus0.writedata = wd; bus0.byteenable = be;
    bus0.read = rd; bus0.write = wr; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus0.waitrequest) break;
      stalls++;
    end
    @(posedge clk); #1;
    bus0.read = 1'b0; bus0.write = 1'b0;
  endtask

  task automatic m2_write(input logic [AB-1:0] a, input logic [DW-1:0] wd, output int stalls);
    bus2.address = a; bus2.writedata = wd; bus2.byteenable = '1;
    bus2.write = 1'b1; bus2.read = 1'b0; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus2.waitrequest) break;
      stalls++;
    end
    @(posedge clk); #1;
    bus2.write = 1'b0;
  endtask

  task automatic m2_read(input logic [AB-1:0] a, input logic [DW-1:0] d, output int stalls);
    bus2.address = a; bus2.read = 1'b1; bus2.write = 1'b0; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus2.waitrequest) break;
      stalls++;
    end
    if (!bus2.waitrequest) q2.push_back('{d, cyc});
    @(posedge clk); #1;
    bus2.read = 1'b0;
  endtask

  task automatic m2_drain(input string tag, input logic [DW-1:0] hold);
    int n = 0;
    while (q2.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, 32'(q2.size()), 32'd0);
    check("m2_rdata_hold", 32'(bus2.readdata), 32'(hold));
    check("m2_rdv_idle", 32'(bus2.readdatavalid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s1, s2, s3;
    bus0.address = '0; bus0.writedata = '0; bus0.byteenable = '0; bus0.read = 1'b0; bus0.write = 1'b0;
    bus2.address = '0; bus2.writedata = '0; bus2.byteenable = '0; bus2.read = 1'b0; bus2.write = 1'b0;

    #3;
    check("rst_wait0", 32'(bus0.waitrequest), 32'd1);
    check("rst_wait2", 32'(bus2.waitrequest), 32'd1);
    check("rst_rdata0", 32'(bus0.readdata), 32'd0);
    check("rst_rdata2", 32'(bus2.readdata), 32'd0);
    check("rst_rdv0", 32'(bus0.readdatavalid), 32'd0);
    check("rst_rdv2", 32'(bus2.readdatavalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Mode 0: full write, readback, partial write, readback
    m0_xfer(1'b0, 1'b1, 8'd5, 16'h1234, 2'b11, s);
    check("m0_wr_stalls", 32'(s), 32'd2);
    q0.push_back(16'h1234);
    m0_xfer(1'b1, 1'b0, 8'd5, 16'h0000, 2'b00, s);
    check("m0_rd_stalls", 32'(s), 32'd2);
    m0_xfer(1'b0, 1'b1, 8'd5, 16'hABCD, 2'b01, s);
    check("m0_be_stalls", 32'(s), 32'd2);
    q0.push_back(16'h12CD);
    m0_xfer(1'b1, 1'b0, 8'd5, 16'h0000, 2'b00, s);
    @(negedge clk);
    check("m0_rd_hold", 32'(bus0.readdata), 32'h12CD);
    @(posedge clk); #1;

    // Read and write together: write wins, no read completion
    m0_xfer(1'b1, 1'b1, 8'd9, 16'h0F0F, 2'b11, s);
    check("m0_conf_stalls", 32'(s), 32'd2);
    check("m0_conf_hold", 32'(bus0.readdata), 32'h12CD);
`ifdef AVS_PROTOCOL_CHECK_EN
    check("m0_err_count", 32'(err0), 32'd3);
`endif
    q0.push_back(16'h0F0F);
    m0_xfer(1'b1, 1'b0, 8'd9, 16'h0000, 2'b00, s);

    // Write abandoned mid-wait leaves memory untouched
    bus0.address = 8'd9; bus0.writedata = 16'hFFFF; bus0.byteenable = 2'b11; bus0.write = 1'b1;
    @(negedge clk);
    check("m0_drop_wait", 32'(bus0.waitrequest), 32'd1);
    @(posedge clk); #1;
    bus0.write = 1'b0;
    @(posedge clk); #1;
    q0.push_back(16'h0F0F);
    m0_xfer(1'b1, 1'b0, 8'd9, 16'h0000, 2'b00, s);
    check("m0_drop_rd_stalls", 32'(s), 32'd2);

    // Mode 2: preload, then three back-to-back reads against MAXPENDING=2
    m2_write(8'd1, 16'h0011, s1);
    m2_write(8'd2, 16'h0022, s2);
    m2_write(8'd3, 16'h0033, s3);
    check("m2_wr_stalls", 32'(s1 + s2 + s3), 32'd0);
    m2_read(8'd1, 16'h0011, s1);
    m2_read(8'd2, 16'h0022, s2);
    m2_read(8'd3, 16'h0033, s3);
    check("m2_rd1_stalls", 32'(s1), 32'd0);
    check("m2_rd2_stalls", 32'(s2), 32'd0);
    check("m2_rd3_stalls", 32'(s3), 32'd2);
    m2_drain("m2_drain_a", 16'h0033);

    m2_write(8'd7, 16'h55AA, s);
    m2_read(8'd7, 16'h55AA, s1);
    check("m2_wr_rd_stalls", 32'(s + s1), 32'd0);
    m2_drain("m2_drain_b", 16'h55AA);

    // Reset with two reads outstanding
    m2_read(8'd1, 16'h0011, s1);
    m2_read(8'd2, 16'h0022, s2);
    rst = 1'b0;
    q2.delete();
    #1;
    check("mrst_rdv", 32'(bus2.readdatavalid), 32'd0);
    check("mrst_wait2", 32'(bus2.waitrequest), 32'd1);
    check("mrst_wait0", 32'(bus0.waitrequest), 32'd1);
    check("mrst_rdata2", 32'(bus2.readdata), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("mrst_rdv_held", 32'(bus2.readdatavalid), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("mrel_wait2_first", 32'(bus2.waitrequest), 32'd1);
    @(negedge clk);
    check("mrel_wait2", 32'(bus2.waitrequest), 32'd0);
    check("mrel_wait0", 32'(bus0.waitrequest), 32'd0);
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;

    // Memory cleared and pending counter empty after reset
    m2_read(8'd7, 16'h0000, s1);
    m2_read(8'd2, 16'h0000, s2);
    check("mrst_pend_stalls", 32'(s1 + s2), 32'd0);
    m2_drain("m2_drain_c", 16'h0000);
    q0.push_back(16'h0000);
    m0_xfer(1'b1, 1'b0, 8'd5, 16'h0000, 2'b00, s);
    check("mrst_m0_stalls", 32'(s), 32'd2);
    check("m0_sb_empty", 32'(q0.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/avalon_slave_mem.md
Name: avalon_slave_mem

Overview:
- Avalon-MM slave memory model that drives the response side of the bus (waitrequest, readdata, readdatavalid) monitored by the bus assertion checker.
- Instantiated in the testbench next to the master; its outputs and the master's signals feed the checker.
- Supports two slave timing modes:
  - waitrequest with programmable wait states (AVALONMODE=0)
  - pipelined variable-latency reads (AVALONMODE=2)

Parameters:
- AVALONMODE, 0, bus timing mode: 0 = waitrequest, 2 = pipelined variable; any other value is an elaboration error ($fatal).
- NBDATABYTES, 2, data bytes per word; data width = 8*NBDATABYTES.
- NBADDRBITS, 8, word address width; memory depth = 2**NBADDRBITS.
- WAITCYCLES, 2, mode 0: wait states per transfer (0..15).
- LATENCY, 3, mode 2: cycles from read acceptance to readdatavalid (1..15).
- MAXPENDING, 2, mode 2: maximum outstanding reads (1..LATENCY).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- address  in  NBADDRBITS  word address
- byteenable  in  NBDATABYTES  per-byte write enable
- writedata  in  8*NBDATABYTES  write data
- read  in  1  read request
- write  in  1  write request
- waitrequest  out  1  slave stall
- readdata  out  8*NBDATABYTES  read data
- readdatavalid  out  1  mode 2 read return strobe; tied 0 in mode 0

Behaviour:
- Reset (rst=0, async):
  - waitrequest forced 1; readdata=0; readdatavalid=0.
  - Memory cleared to 0; wait counter, pending counter and response pipeline cleared.
  - Reset mid-transfer discards the transfer and all outstanding reads; no readdatavalid after reset release.
- Request conflict: read&write in the same cycle → the write is performed, the read is ignored.
- Mode 0 FSM, states IDLE and WAIT, counter wcnt (4 bits):
  - IDLE: if (read|write): WAITCYCLES=0 → transfer completes this cycle; else go to WAIT with wcnt=1.
  - waitrequest = (read|write) && (wcnt != WAITCYCLES), combinational.
  - WAIT: wcnt increments each cycle while waitrequest=1. The transfer completes in the cycle where waitrequest=0; the FSM then returns to IDLE with wcnt=0.
  - Write completion: on that edge, mem[address] updated per byteenable bit.
  - Read completion: readdata = mem[address] combinationally during the completion cycle; readdata holds its last value otherwise.
  - Master drops read/write while in WAIT → return to IDLE, wcnt=0, no memory update.
  - Back-to-back requests: each transfer takes exactly WAITCYCLES+1 cycles.
- Mode 2 (pipelined):
  - waitrequest = (pending == MAXPENDING), from registers only; no same-cycle bypass.
  - Read accepted when read && !waitrequest: data mem[address] is captured at acceptance into the response pipeline (avalon_rsp_pipe).
  - readdatavalid=1 with that data exactly LATENCY cycles after the acceptance edge; returns are in order, one per cycle max.
  - Write accepted when write && !waitrequest; memory is updated at the acceptance edge. A read accepted in a later cycle returns the new data.
  - pending (width $clog2(MAXPENDING+1)):
    - +1 on an accepted read
    - −1 on readdatavalid
    - both in the same cycle → unchanged
    - never exceeds MAXPENDING and never goes below 0
  - readdata holds the last returned value while readdatavalid=0.

Optional Feature:
- Macro AVS_PROTOCOL_CHECK_EN.
- Defined:
  - Extra output port err_count (16 bits, reset 0, saturating).
  - Increments once per cycle in which read&write=1, or (mode 0) request/address/writedata changes while waitrequest=1.
  - Issues $error with $time on each such event.
- Undefined: no err_count port, no checking logic; bus behaviour identical.

Decomposition:
- Package avalon_pkg holds:
  - avalon_mode_e enum: WAITREQ=0, FIXED=1, PIPE_VAR=2, PIPE_FIX=3, BURST=4
  - mode-0 state enum: IDLE, WAIT
  - parameterised width helpers for data and byteenable
- One sub-module, avalon_rsp_pipe:
  - LATENCY-deep shift register of {valid, data}
  - input push/data, output valid/data
  - async active-low reset clears the valid bits

Test Plan:
- Mode 0, WAITCYCLES=2: write 0x1234 to addr 5 (be=11), then read addr 5 → waitrequest high 2 cycles each, readdata=0x1234 in the third cycle of the read.
- Mode 0, byteenable=01: write 0xABCD over 0x1234 at addr 5, read back → 0x12CD.
- Mode 2, LATENCY=3, MAXPENDING=2: reads of addr 1,2,3 back-to-back (preloaded 0x11,0x22,0x33):
  - waitrequest=1 in the cycle after 2 are accepted
  - readdatavalid on the edges 3 and 4 after the first acceptance
  - third read accepted after the first return; all data returned in order
- Mode 2: write 0x55AA to addr 7 then immediate read addr 7 → readdatavalid 3 cycles later with 0x55AA.
- Reset asserted with 2 reads pending → readdatavalid stays 0, pending=0, waitrequest=1 during reset and 0 one cycle after release.
- With AVS_PROTOCOL_CHECK_EN: drive read=write=1 for 3 cycles → err_count=3; the write is committed and no read response occurs.
